// File: rtl/phys_mem_ctrl_pkg.sv
// Shared address map, COM status bit positions, FSM encoding and the address decoder
// used by the physical memory controller.
package phys_mem_ctrl_pkg;

   localparam logic [31:0] COM_DATA_ADDR = 32'h1FD0_03F8;
   localparam logic [31:0] COM_STAT_ADDR = 32'h1FD0_03FC;

   localparam int COM_STAT_TX_READY = 0;
   localparam int COM_STAT_RX_PEND  = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SRAM_ACC,
      ST_SRAM_END,
      ST_COM_TX
   } state_e;

   typedef enum logic [1:0] {
      RGN_NONE,
      RGN_SRAM,
      RGN_COM_DATA,
      RGN_COM_STAT
   } region_e;

   // COM registers are matched on the word address; SRAM occupies the low 2^(aw+2) bytes.
   function automatic region_e decode_region(input logic [31:0] addr, input int sram_aw);
      if (addr[31:2] == COM_DATA_ADDR[31:2]) return RGN_COM_DATA;
      if (addr[31:2] == COM_STAT_ADDR[31:2]) return RGN_COM_STAT;
      if ((addr >> (sram_aw + 2)) == 32'd0)  return RGN_SRAM;
      return RGN_NONE;
   endfunction

endpackage

// File: rtl/phys_mem_ctrl_com_rx_fifo.sv
// Receive storage for COM bytes. With PHYS_MEM_RX_FIFO_EN defined it is a 2^LOG-entry FIFO
// (push when full is dropped); otherwise a single holding register where new bytes overwrite.
module phys_mem_ctrl_com_rx_fifo #(
   parameter int LOG = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);

`ifdef PHYS_MEM_RX_FIFO_EN
   localparam int DEPTH = 1 << LOG;

   logic [7:0]   mem [DEPTH];
   logic [LOG:0] wr_ptr;
   logic [LOG:0] rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[LOG] != rd_ptr[LOG]) && (wr_ptr[LOG-1:0] == rd_ptr[LOG-1:0]);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts that push.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr[LOG-1:0]];

   // NOTE: the storage array is deliberately not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[LOG-1:0]] <= push_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end
`else
   logic [7:0] hold;
   logic       pending;
   logic       unused_log;

   assign unused_log = (LOG > 0);
   assign rdata      = hold;
   assign empty      = !pending;
   assign full       = pending;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold    <= 8'h00;
         pending <= 1'b0;
      end else if (push) begin
         hold    <= push_data;
         pending <= 1'b1;
      end else if (pop) begin
         pending <= 1'b0;
      end
   end
`endif

endmodule

// File: rtl/phys_mem_ctrl.sv
// Physical memory controller: decodes cpu accesses to SRAM or the COM register pair and
// sequences SRAM strobe timing. PHYS_MEM_RX_FIFO_EN selects a FIFO for received COM bytes.
module phys_mem_ctrl
   import phys_mem_ctrl_pkg::*;
#(
   parameter int SRAM_ADDR_WIDTH = 20,
   parameter int SRAM_WAIT       = 2,
   parameter int RX_FIFO_LOG     = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                dev_mem_addr,
   input  logic [31:0]                dev_mem_data_in,
   input  logic                       dev_mem_is_write,
   output logic [31:0]                dev_mem_data_out,
   output logic                       dev_mem_busy,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic [31:0]                sram_wdata,
   output logic                       sram_data_oe,
   input  logic [31:0]                sram_rdata,
   output logic                       sram_ce_n,
   output logic                       sram_oe_n,
   output logic                       sram_we_n,
   output logic [7:0]                 com_tx_data,
   output logic                       com_tx_valid,
   input  logic                       com_tx_ready,
   input  logic [7:0]                 com_rx_data,
   input  logic                       com_rx_valid,
   output logic                       int_com_req
);

   localparam logic [3:0] WAIT_LAST = 4'(SRAM_WAIT - 1);

   state_e      state;
   state_e      state_next;
   logic [3:0]  wait_cnt;
   logic [29:0] tag_addr;
   logic        tag_wr;
   logic        tag_valid;
   logic        tag_hit;
   logic        start;
   logic        acc_wr;
   region_e     region;
   logic [31:0] com_stat;

   logic        rx_pop;
   logic [7:0]  rx_rdata;
   logic        rx_full;
   logic        rx_empty;
   logic        unused_rx_full;

   assign unused_rx_full = rx_full;

   // A request still presented after it completed matches the tag and is not reissued.
   assign region  = decode_region(dev_mem_addr, SRAM_ADDR_WIDTH);
   assign tag_hit = tag_valid && (tag_addr == dev_mem_addr[31:2]) && (tag_wr == dev_mem_is_write);
   assign start   = (state == ST_IDLE) && !tag_hit;

   assign dev_mem_busy = start || (state != ST_IDLE);
   assign rx_pop       = start && (region == RGN_COM_DATA) && !dev_mem_is_write && !rx_empty;
   assign int_com_req  = !rx_empty;

   always_comb begin
      com_stat                    = '0;
      com_stat[COM_STAT_TX_READY] = com_tx_ready;
      com_stat[COM_STAT_RX_PEND]  = !rx_empty;
   end

   phys_mem_ctrl_com_rx_fifo #(
      .LOG (RX_FIFO_LOG)
   ) u_com_rx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (com_rx_valid),
      .push_data (com_rx_data),
      .pop       (rx_pop),
      .rdata     (rx_rdata),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   // NOTE: every signal assigned here gets a default first so no path can infer a latch.
   always_comb begin
      state_next   = state;
      sram_ce_n    = 1'b1;
      sram_oe_n    = 1'b1;
      sram_we_n    = 1'b1;
      sram_data_oe = 1'b0;
      com_tx_valid = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               if (region == RGN_SRAM)
                  state_next = ST_SRAM_ACC;
               else if ((region == RGN_COM_DATA) && dev_mem_is_write)
                  state_next = ST_COM_TX;
            end
         end
         ST_SRAM_ACC: begin
            sram_ce_n    = 1'b0;
            sram_oe_n    = acc_wr;
            sram_we_n    = !acc_wr;
            sram_data_oe = acc_wr;
            if (wait_cnt == WAIT_LAST) state_next = ST_SRAM_END;
         end
         ST_SRAM_END: begin
            // Strobes released with chip enable and write data held for hold time.
            sram_ce_n    = 1'b0;
            sram_data_oe = acc_wr;
            state_next   = ST_IDLE;
         end
         ST_COM_TX: begin
            com_tx_valid = 1'b1;
            if (com_tx_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= ST_IDLE;
         wait_cnt         <= 4'd0;
         tag_addr         <= '0;
         tag_wr           <= 1'b0;
         tag_valid        <= 1'b0;
         acc_wr           <= 1'b0;
         sram_addr        <= '0;
         sram_wdata       <= '0;
         com_tx_data      <= 8'h00;
         dev_mem_data_out <= '0;
      end else begin
         state <= state_next;

         if (state == ST_SRAM_ACC) wait_cnt <= wait_cnt + 4'd1;
         else                      wait_cnt <= 4'd0;

         // The tag is loaded at start; busy stays high on state until the access really ends.
         if (start) begin
            tag_addr  <= dev_mem_addr[31:2];
            tag_wr    <= dev_mem_is_write;
            tag_valid <= 1'b1;

            case (region)
               RGN_SRAM: begin
                  sram_addr  <= dev_mem_addr[SRAM_ADDR_WIDTH+1:2];
                  sram_wdata <= dev_mem_data_in;
                  acc_wr     <= dev_mem_is_write;
               end
               RGN_COM_DATA: begin
                  if (dev_mem_is_write)
                     com_tx_data <= dev_mem_data_in[7:0];
                  else
                     dev_mem_data_out <= rx_empty ? 32'd0 : {24'd0, rx_rdata};
               end
               RGN_COM_STAT: begin
                  if (!dev_mem_is_write) dev_mem_data_out <= com_stat;
               end
               default: begin
                  if (!dev_mem_is_write) dev_mem_data_out <= 32'd0;
               end
            endcase
         end

         if ((state == ST_SRAM_END) && !acc_wr) dev_mem_data_out <= sram_rdata;
      end
   end

endmodule

// File: tb/tb_phys_mem_ctrl.sv
// Directed bench for phys_mem_ctrl: SRAM timing, coalescing, COM TX/RX, unmapped access, reset.
// The RX section follows PHYS_MEM_RX_FIFO_EN so the same bench covers both builds.
module tb_phys_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dev_mem_addr;
   logic [31:0] dev_mem_data_in;
   logic        dev_mem_is_write;
   logic [31:0] dev_mem_data_out;
   logic        dev_mem_busy;
   logic [19:0] sram_addr;
   logic [31:0] sram_wdata;
   logic        sram_data_oe;
   logic [31:0] sram_rdata;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_we_n;
   logic [7:0]  com_tx_data;
   logic        com_tx_valid;
   logic        com_tx_ready;
   logic [7:0]  com_rx_data;
   logic        com_rx_valid;
   logic        int_com_req;

   int checks   = 0;
   int failures = 0;

   int ce_low = 0;
   int we_low = 0;
   int oe_low = 0;

   logic [31:0] sram_mem [256];

   localparam logic [31:0] COM_DATA = 32'h1FD0_03F8;
   localparam logic [31:0] COM_STAT = 32'h1FD0_03FC;

   phys_mem_ctrl #(
      .SRAM_ADDR_WIDTH (20),
      .SRAM_WAIT       (2),
      .RX_FIFO_LOG     (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .dev_mem_addr     (dev_mem_addr),
      .dev_mem_data_in  (dev_mem_data_in),
      .dev_mem_is_write (dev_mem_is_write),
      .dev_mem_data_out (dev_mem_data_out),
      .dev_mem_busy     (dev_mem_busy),
      .sram_addr        (sram_addr),
      .sram_wdata       (sram_wdata),
      .sram_data_oe     (sram_data_oe),
      .sram_rdata       (sram_rdata),
      .sram_ce_n        (sram_ce_n),
      .sram_oe_n        (sram_oe_n),
      .sram_we_n        (sram_we_n),
      .com_tx_data      (com_tx_data),
      .com_tx_valid     (com_tx_valid),
      .com_tx_ready     (com_tx_ready),
      .com_rx_data      (com_rx_data),
      .com_rx_valid     (com_rx_valid),
      .int_com_req      (int_com_req)
   );

   always #5 clk = ~clk;

   // Asynchronous SRAM model: data valid while selected, write on each clock with we_n low.
   assign sram_rdata = !sram_ce_n ? sram_mem[sram_addr[7:0]] : 32'hBAD0_BAD0;

   always @(posedge clk) begin
      if (!sram_ce_n && !sram_we_n && sram_data_oe) sram_mem[sram_addr[7:0]] <= sram_wdata;
   end

   always @(negedge clk) begin
      if (!sram_ce_n) ce_low++;
      if (!sram_we_n) we_low++;
      if (!sram_oe_n) oe_low++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the first busy-low cycle.
   task automatic wait_idle(output int busy_n, output logic [31:0] rd, output logic irq);
      busy_n = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (!dev_mem_busy) break;
         busy_n++;
         @(posedge clk); #1;
      end
      rd  = dev_mem_data_out;
      irq = int_com_req;
      @(posedge clk); #1;
   endtask

   task automatic access(input logic [31:0] addr, input logic [31:0] data, input logic wr,
                         output int busy_n, output logic [31:0] rd, output logic irq);
      dev_mem_addr     = addr;
      dev_mem_data_in  = data;
      dev_mem_is_write = wr;
      wait_idle(busy_n, rd, irq);
   endtask

   task automatic rx_byte(input logic [7:0] b);
      com_rx_data  = b;
      com_rx_valid = 1'b1;
      @(posedge clk); #1;
      com_rx_valid = 1'b0;
   endtask

   initial begin
      int          busy_n;
      logic [31:0] rd;
      logic        irq;
      int          we0, oe0, ce0, tmp;

      for (int i = 0; i < 256; i++) sram_mem[i] = 32'h0;
      rst              = 1'b0;
      dev_mem_addr     = 32'h3000_0000;
      dev_mem_data_in  = 32'h0;
      dev_mem_is_write = 1'b0;
      com_tx_ready     = 1'b0;
      com_rx_data      = 8'h00;
      com_rx_valid     = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_strobes", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, 32'hE);
      check("rst_data_out", dev_mem_data_out, 32'h0);
      check("rst_addr_wdata", {12'd0, sram_addr} | sram_wdata, 32'h0);
      check("rst_com", {29'd0, com_tx_valid, int_com_req, |com_tx_data}, 32'h0);
      check("rst_busy", {31'd0, dev_mem_busy}, 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;

      // SRAM write then read, SRAM_WAIT=2
      we0 = we_low; oe0 = oe_low;
      access(32'h0000_0100, 32'hDEAD_BEEF, 1'b1, busy_n, rd, irq);
      check("wr_busy_cycles", busy_n, 4);
      check("wr_we_low", we_low - we0, 2);
      check("wr_oe_low", oe_low - oe0, 0);
      check("wr_sram_addr", {12'd0, sram_addr}, 32'h40);
      check("wr_sram_mem", sram_mem[8'h40], 32'hDEAD_BEEF);

      we0 = we_low; oe0 = oe_low;
      access(32'h0000_0100, 32'h0, 1'b0, busy_n, rd, irq);
      check("rd_busy_cycles", busy_n, 4);
      check("rd_data", rd, 32'hDEAD_BEEF);
      check("rd_oe_low", oe_low - oe0, 2);
      check("rd_we_low", we_low - we0, 0);

      // Held read is coalesced
      ce0 = ce_low; tmp = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (dev_mem_busy) tmp++;
         @(posedge clk); #1;
      end
      check("hold_busy", tmp, 0);
      check("hold_no_ce", ce_low - ce0, 0);
      check("hold_data", dev_mem_data_out, 32'hDEAD_BEEF);

      // COM write with ready low for five cycles
      com_tx_ready     = 1'b0;
      dev_mem_addr     = COM_DATA;
      dev_mem_data_in  = 32'hFFFF_FF41;
      dev_mem_is_write = 1'b1;
      busy_n = 0; tmp = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (dev_mem_busy) busy_n++;
         if (com_tx_valid) tmp++;
         @(posedge clk); #1;
      end
      check("tx_busy_wait", busy_n, 6);
      check("tx_valid_wait", tmp, 5);
      com_tx_ready = 1'b1;
      @(negedge clk);
      check("tx_ready_cycle", {30'd0, dev_mem_busy, com_tx_valid}, 32'h3);
      check("tx_data", {24'd0, com_tx_data}, 32'h41);
      @(posedge clk); #1;
      @(negedge clk);
      check("tx_done", {30'd0, dev_mem_busy, com_tx_valid}, 32'h0);
      @(posedge clk); #1;

      // RX byte, status and data reads
      rx_byte(8'h5A);
      @(negedge clk);
      check("rx_irq", {31'd0, int_com_req}, 32'h1);
      @(posedge clk); #1;
      access(COM_STAT, 32'h0, 1'b0, busy_n, rd, irq);
      check("stat_rd", rd, 32'h3);
      check("stat_busy", busy_n, 1);
      access(COM_DATA, 32'h0, 1'b0, busy_n, rd, irq);
      check("rx_rd", rd, 32'h0000_005A);
      check("rx_irq_clear", {31'd0, irq}, 32'h0);

      // Unmapped and empty COM read
      access(32'h2000_0000, 32'h0, 1'b0, busy_n, rd, irq);
      check("unmapped_busy", busy_n, 1);
      check("unmapped_rd", rd, 32'h0);
      access(32'h0000_0100, 32'h0, 1'b0, busy_n, rd, irq);
      check("reread_sram", rd, 32'hDEAD_BEEF);
      access(COM_DATA, 32'h0, 1'b0, busy_n, rd, irq);
      check("rx_empty_rd", rd, 32'h0);

      // Push and pop in the same cycle
      rx_byte(8'h77);
      access(COM_STAT, 32'h0, 1'b0, busy_n, rd, irq);
      check("stat_pending", rd, 32'h3);
      dev_mem_addr     = COM_DATA;
      dev_mem_is_write = 1'b0;
      com_rx_data      = 8'h88;
      com_rx_valid     = 1'b1;
      @(negedge clk);
      check("pp_busy", {31'd0, dev_mem_busy}, 32'h1);
      @(posedge clk); #1;
      com_rx_valid = 1'b0;
      @(negedge clk);
      check("pp_data", dev_mem_data_out, 32'h77);
      check("pp_irq", {31'd0, int_com_req}, 32'h1);
      @(posedge clk); #1;
      access(COM_STAT, 32'h0, 1'b0, busy_n, rd, irq);
      access(COM_DATA, 32'h0, 1'b0, busy_n, rd, irq);
      check("pp_second", rd, 32'h88);
      check("pp_irq_clear", {31'd0, irq}, 32'h0);

`ifdef PHYS_MEM_RX_FIFO_EN
      // 17 pushes into a 16-entry FIFO: the last is dropped
      for (int i = 0; i < 17; i++) rx_byte(8'(8'h30 + i));
      for (int i = 0; i < 16; i++) begin
         access(COM_STAT, 32'h0, 1'b0, busy_n, rd, irq);
         check("fifo_stat", rd, 32'h3);
         access(COM_DATA, 32'h0, 1'b0, busy_n, rd, irq);
         check("fifo_data", rd, 32'h30 + 32'(i));
      end
      access(COM_STAT, 32'h0, 1'b0, busy_n, rd, irq);
      check("fifo_drained", rd, 32'h1);
`else
      // Holding register: the newer byte overwrites the unread one
      rx_byte(8'h11);
      rx_byte(8'h22);
      access(COM_STAT, 32'h0, 1'b0, busy_n, rd, irq);
      check("hold_stat", rd, 32'h3);
      access(COM_DATA, 32'h0, 1'b0, busy_n, rd, irq);
      check("hold_overwrite", rd, 32'h22);
      access(COM_STAT, 32'h0, 1'b0, busy_n, rd, irq);
      check("hold_drained", rd, 32'h1);
`endif

      // Reset in the middle of an SRAM write
      dev_mem_addr     = 32'h0000_0200;
      dev_mem_data_in  = 32'h1234_5678;
      dev_mem_is_write = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      check("mid_we_low", {31'd0, sram_we_n}, 32'h0);
      rst = 1'b0;
      #1;
      check("mid_rst_strobes", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, 32'hE);
      check("mid_rst_busy", {31'd0, dev_mem_busy}, 32'h1);
      check("mid_rst_data", dev_mem_data_out, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      wait_idle(busy_n, rd, irq);
      check("post_rst_wr_busy", busy_n, 4);
      access(32'h0000_0200, 32'h0, 1'b0, busy_n, rd, irq);
      check("post_rst_rd_busy", busy_n, 4);
      check("post_rst_rd", rd, 32'h1234_5678);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
